// File: rtl/b_wb.sv
// b_wb: MIPS writeback stage. Holds the MEM/WB pipeline register, selects the
// writeback result (ALU, big-endian load extraction, link address), drives the
// register-file write port plus an identical bypass copy, and counts retired
// instructions.
module b_wb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              i_sys_clock,
  input  logic              i_sys_reset,
  input  logic              i_b_wb_valid,
  input  logic              i_b_wb_stall,
  input  logic              i_b_wb_flush,
  input  logic              i_b_wb_regwr,
  input  logic [ADDR_W-1:0] i_b_wb_wr_addr,
  input  logic [1:0]        i_b_wb_result_sel,
  input  logic [1:0]        i_b_wb_load_size,
  input  logic              i_b_wb_load_signed,
  input  logic [DATA_W-1:0] i_b_wb_alu_result,
  input  logic [DATA_W-1:0] i_b_wb_mem_rdata,
  input  logic [DATA_W-1:0] i_b_wb_pc_plus8,
  output logic              o_b_wb_regwr,
  output logic [ADDR_W-1:0] o_b_wb_wr_addr,
  output logic [DATA_W-1:0] o_b_wb_wr_data,
  output logic              o_b_wb_fwd_valid,
  output logic [ADDR_W-1:0] o_b_wb_fwd_addr,
  output logic [DATA_W-1:0] o_b_wb_fwd_data,
  output logic              o_b_wb_misalign,
  output logic [31:0]       o_b_wb_retire_count
);

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;

  logic              valid_q,  valid_d;
  logic              regwr_q,  regwr_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [1:0]        sel_q,    sel_d;
  logic [1:0]        size_q,   size_d;
  logic              signed_q, signed_d;
  logic [DATA_W-1:0] alu_q,    alu_d;
  logic [DATA_W-1:0] mem_q,    mem_d;
  logic [DATA_W-1:0] link_q,   link_d;
  logic [CNT_W-1:0]  retire_q, retire_d;

  logic [1:0]        off;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] result;
  logic              misaligned;
  logic              misalign;
  logic              we;

  // Stage-register next state: flush kills, stall holds, otherwise load.
  always_comb begin
    valid_d  = valid_q;
    regwr_d  = regwr_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    size_d   = size_q;
    signed_d = signed_q;
    alu_d    = alu_q;
    mem_d    = mem_q;
    link_d   = link_q;
    if (i_b_wb_flush) begin
      valid_d = 1'b0;
    end else if (!i_b_wb_stall) begin
      valid_d  = i_b_wb_valid;
      regwr_d  = i_b_wb_regwr;
      addr_d   = i_b_wb_wr_addr;
      sel_d    = i_b_wb_result_sel;
      size_d   = i_b_wb_load_size;
      signed_d = i_b_wb_load_signed;
      alu_d    = i_b_wb_alu_result;
      mem_d    = i_b_wb_mem_rdata;
      link_d   = i_b_wb_pc_plus8;
    end
  end

  // An instruction retires when it leaves the stage (held valid, not stalled).
  always_comb begin
    retire_d = retire_q;
    if (valid_q && !i_b_wb_stall) begin
      retire_d = retire_q + CNT_W'(1);
    end
  end

  // Stage register and retire counter with synchronous reset.
  always_ff @(posedge i_sys_clock) begin
    if (i_sys_reset) begin
      valid_q  <= 1'b0;
      regwr_q  <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      alu_q    <= '0;
      mem_q    <= '0;
      link_q   <= '0;
      retire_q <= '0;
    end else begin
      valid_q  <= valid_d;
      regwr_q  <= regwr_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      alu_q    <= alu_d;
      mem_q    <= mem_d;
      link_q   <= link_d;
      retire_q <= retire_d;
    end
  end

  assign off = alu_q[1:0];

  // Big-endian lane extraction: offset 0 is the most significant byte.
  always_comb begin
    load_byte = 8'h00;
    case (off)
      2'd0:    load_byte = mem_q[31:24];
      2'd1:    load_byte = mem_q[23:16];
      2'd2:    load_byte = mem_q[15:8];
      default: load_byte = mem_q[7:0];
    endcase
    load_half = off[1] ? mem_q[15:0] : mem_q[31:16];
  end

  // Width select with sign or zero extension.
  always_comb begin
    load_val = mem_q;
    case (size_q)
      SZ_BYTE: load_val = {{(DATA_W-8){signed_q & load_byte[7]}}, load_byte};
      SZ_HALF: load_val = {{(DATA_W-16){signed_q & load_half[15]}}, load_half};
      default: load_val = mem_q;
    endcase
  end

  // Half loads need even offsets, word loads need offset zero.
  always_comb begin
    misaligned = 1'b0;
    if (sel_q == SEL_MEM) begin
      if (size_q == SZ_HALF) begin
        misaligned = off[0];
      end else if (size_q != SZ_BYTE) begin
        misaligned = (off != 2'd0);
      end
    end
  end

  // Result mux; the unused encoding falls back to the ALU result.
  always_comb begin
    result = alu_q;
    case (sel_q)
      SEL_MEM:  result = load_val;
      SEL_LINK: result = link_q;
      default:  result = alu_q;
    endcase
  end

  assign misalign = valid_q & misaligned;
  assign we       = valid_q & regwr_q & (addr_q != '0) & ~misalign;

  assign o_b_wb_regwr        = we;
  assign o_b_wb_wr_addr      = addr_q;
  assign o_b_wb_wr_data      = result;
  assign o_b_wb_fwd_valid    = we;
  assign o_b_wb_fwd_addr     = addr_q;
  assign o_b_wb_fwd_data     = result;
  assign o_b_wb_misalign     = misalign;
  assign o_b_wb_retire_count = retire_q;

endmodule

// File: tb/tb_b_wb.sv
// Directed bench for the b_wb writeback stage with an expected-result queue.
module tb_b_wb;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        valid, stall, flush, regwr, sgn;
  logic [4:0]  addr;
  logic [1:0]  sel, size;
  logic [31:0] alu, rdata, pc8;

  logic        o_regwr, o_fwd_valid, o_mis;
  logic [4:0]  o_addr, o_fwd_addr;
  logic [31:0] o_data, o_fwd_data, o_cnt;

  int checks;
  int failures;

  exp_t        sb[$];
  exp_t        e;
  logic        mv;
  logic [31:0] cnt;

  b_wb dut (
    .i_sys_clock        (clk),
    .i_sys_reset        (rst),
    .i_b_wb_valid       (valid),
    .i_b_wb_stall       (stall),
    .i_b_wb_flush       (flush),
    .i_b_wb_regwr       (regwr),
    .i_b_wb_wr_addr     (addr),
    .i_b_wb_result_sel  (sel),
    .i_b_wb_load_size   (size),
    .i_b_wb_load_signed (sgn),
    .i_b_wb_alu_result  (alu),
    .i_b_wb_mem_rdata   (rdata),
    .i_b_wb_pc_plus8    (pc8),
    .o_b_wb_regwr       (o_regwr),
    .o_b_wb_wr_addr     (o_addr),
    .o_b_wb_wr_data     (o_data),
    .o_b_wb_fwd_valid   (o_fwd_valid),
    .o_b_wb_fwd_addr    (o_fwd_addr),
    .o_b_wb_fwd_data    (o_fwd_data),
    .o_b_wb_misalign    (o_mis),
    .o_b_wb_retire_count(o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected writeback for one instruction, computed from the raw inputs.
  function automatic exp_t make_exp(input logic rw, input logic [4:0] a, input logic [1:0] s,
                                    input logic [1:0] sz, input logic sg, input logic [31:0] al,
                                    input logic [31:0] rd, input logic [31:0] pc);
    exp_t r;
    int   o;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld;
    o  = int'(al[1:0]);
    b  = 8'((rd >> (8 * (3 - o))) & 32'hFF);
    h  = (o >= 2) ? rd[15:0] : rd[31:16];
    if (sz == 2'b00)      ld = sg ? 32'(signed'(b)) : {24'h0, b};
    else if (sz == 2'b01) ld = sg ? 32'(signed'(h)) : {16'h0, h};
    else                  ld = rd;
    r.mis  = (s == 2'b01) && ((sz == 2'b01 && (o % 2) == 1) || (sz[1] && o != 0));
    r.addr = a;
    r.data = (s == 2'b01) ? ld : (s == 2'b10) ? pc : al;
    r.we   = rw && (a != 5'd0) && !r.mis;
    return r;
  endfunction

  // Drive one instruction and queue its expected writeback.
  task automatic issue(input logic rw, input logic [4:0] a, input logic [1:0] s,
                       input logic [1:0] sz, input logic sg, input logic [31:0] al,
                       input logic [31:0] rd, input logic [31:0] pc);
    valid = 1'b1; regwr = rw; addr = a; sel = s; size = sz; sgn = sg;
    alu = al; rdata = rd; pc8 = pc;
    sb.push_back(make_exp(rw, a, s, sz, sg, al, rd, pc));
  endtask

  // Advance one clock from a falling edge, updating the valid/counter model.
  task automatic tick();
    if (rst) begin
      mv = 1'b0; cnt = 32'h0;
    end else begin
      if (mv && !stall) cnt = cnt + 32'h1;
      if (flush) mv = 1'b0;
      else if (!stall) mv = valid;
    end
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input exp_t x);
    chk({tag, ".regwr"},     32'(o_regwr),     32'(x.we));
    chk({tag, ".wr_addr"},   32'(o_addr),      32'(x.addr));
    chk({tag, ".wr_data"},   o_data,           x.data);
    chk({tag, ".fwd_valid"}, 32'(o_fwd_valid), 32'(x.we));
    chk({tag, ".fwd_addr"},  32'(o_fwd_addr),  32'(x.addr));
    chk({tag, ".fwd_data"},  o_fwd_data,       x.data);
    chk({tag, ".misalign"},  32'(o_mis),       32'(x.mis));
    chk({tag, ".retire"},    o_cnt,            cnt);
  endtask

  task automatic pop_check(input string tag);
    if (sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check_all(tag, e);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    mv = 1'b0; cnt = 32'h0;
    rst = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; regwr = 1'b0;
    addr = '0; sel = '0; size = '0; sgn = 1'b0; alu = '0; rdata = '0; pc8 = '0;

    // Reset for two cycles, then idle.
    tick(); tick();
    rst = 1'b0;
    tick();
    check_all("reset", exp_t'(0));

    // ALU write.
    issue(1'b1, 5'd8, 2'b00, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 32'h0);
    tick(); pop_check("alu");

    // Loads from 0x80FF7F01.
    issue(1'b1, 5'd2, 2'b01, 2'b00, 1'b1, 32'h100, 32'h80FF_7F01, 32'h0);
    tick(); pop_check("lb_off0");
    chk("lb_off0.const", o_data, 32'hFFFF_FF80);
    issue(1'b1, 5'd3, 2'b01, 2'b00, 1'b0, 32'h101, 32'h80FF_7F01, 32'h0);
    tick(); pop_check("lbu_off1");
    chk("lbu_off1.const", o_data, 32'h0000_00FF);
    issue(1'b1, 5'd4, 2'b01, 2'b01, 1'b1, 32'h102, 32'h80FF_7F01, 32'h0);
    tick(); pop_check("lh_off2");
    chk("lh_off2.const", o_data, 32'h0000_7F01);
    issue(1'b1, 5'd5, 2'b01, 2'b01, 1'b1, 32'h101, 32'h80FF_7F01, 32'h0);
    tick(); pop_check("lh_off1_mis");
    chk("lh_off1_mis.const", 32'(o_mis), 32'h1);
    issue(1'b1, 5'd6, 2'b01, 2'b01, 1'b1, 32'h100, 32'h80FF_7F01, 32'h0);
    tick(); pop_check("lh_off0");
    issue(1'b1, 5'd7, 2'b01, 2'b01, 1'b0, 32'h100, 32'h80FF_7F01, 32'h0);
    tick(); pop_check("lhu_off0");
    issue(1'b1, 5'd9, 2'b01, 2'b00, 1'b1, 32'h103, 32'h80FF_7F01, 32'h0);
    tick(); pop_check("lb_off3");
    issue(1'b1, 5'd10, 2'b01, 2'b10, 1'b0, 32'h100, 32'h80FF_7F01, 32'h0);
    tick(); pop_check("lw_off0");
    issue(1'b1, 5'd11, 2'b01, 2'b11, 1'b0, 32'h102, 32'h80FF_7F01, 32'h0);
    tick(); pop_check("lw_off2_mis");

    // Link, sel=11, $0 target, and regwr=0.
    issue(1'b1, 5'd31, 2'b10, 2'b10, 1'b0, 32'h0000_0055, 32'h0, 32'h0040_0010);
    tick(); pop_check("link");
    issue(1'b1, 5'd12, 2'b11, 2'b00, 1'b0, 32'hCAFE_0001, 32'h1234_5678, 32'h9);
    tick(); pop_check("sel11");
    issue(1'b1, 5'd0, 2'b00, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    tick(); pop_check("zero_reg");
    issue(1'b0, 5'd13, 2'b00, 2'b10, 1'b0, 32'h0000_0077, 32'h0, 32'h0);
    tick(); pop_check("no_regwr");

    // Stall for three cycles: write held, single retirement after release.
    issue(1'b1, 5'd14, 2'b00, 2'b10, 1'b0, 32'h0000_ABCD, 32'h0, 32'h0);
    tick(); pop_check("stall_load");
    alu = 32'h1111_1111; addr = 5'd15; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_all("stall_hold", e);
    end
    stall = 1'b0; valid = 1'b0;
    tick();
    chk("stall_release.regwr", 32'(o_regwr), 32'h0);
    chk("stall_release.retire", o_cnt, cnt);

    // Flush together with stall: flush wins, other fields held.
    issue(1'b1, 5'd16, 2'b00, 2'b10, 1'b0, 32'h0000_5A5A, 32'h0, 32'h0);
    tick(); pop_check("flush_load");
    stall = 1'b1; flush = 1'b1; alu = 32'h2222_2222;
    tick();
    e.we = 1'b0; e.mis = 1'b0;
    check_all("flush_stall", e);
    stall = 1'b0; flush = 1'b0; valid = 1'b0;
    tick();

    // Reset during a stall clears everything.
    issue(1'b1, 5'd17, 2'b00, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'h0);
    tick(); pop_check("rst_stall_load");
    stall = 1'b1;
    tick(); check_all("rst_stall_hold", e);
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; stall = 1'b0; valid = 1'b0;
    check_all("rst_stall", exp_t'(0));

    // Five back-to-back retirements from a cleared counter.
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 5'(20 + i), 2'b00, 2'b10, 1'b0, 32'(i * 3 + 1), 32'h0, 32'h0);
      tick(); pop_check("b2b");
    end
    valid = 1'b0;
    tick();
    chk("b2b.count", o_cnt, 32'd5);

    // Counter wrap from all-ones.
    issue(1'b1, 5'd25, 2'b00, 2'b10, 1'b0, 32'h0000_0042, 32'h0, 32'h0);
    tick(); pop_check("wrap_load");
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    cnt = 32'hFFFF_FFFF;
    valid = 1'b0;
    @(negedge clk);
    cnt = 32'h0;
    chk("wrap.count", o_cnt, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
